// File: rtl/reflet_uart_bus_bridge.sv
// UART-driven bus master: decodes 'W'/'R' command frames from rx, performs one
// bus access and reports the outcome ('K', read data, '?' or '!') on tx.
module reflet_uart_bus_bridge #(
   parameter int unsigned wordsize  = 16,
   parameter int unsigned addr_size = 16,
   parameter int unsigned clk_frec  = 1000000,
   parameter int unsigned baud      = 9600
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic                 tx,
   output logic                 bus_enable,
   output logic [addr_size-1:0] bus_addr,
   output logic                 bus_write_en,
   output logic [wordsize-1:0]  bus_wdata,
   input  logic [wordsize-1:0]  bus_rdata,
   output logic                 busy
);

   localparam int unsigned DIV   = clk_frec / baud;
   localparam int unsigned DB    = wordsize / 8;
   localparam int unsigned AB    = addr_size / 8;
   localparam int unsigned MAXB  = (AB > DB) ? AB : DB;
   localparam int unsigned DIV_W = $clog2(DIV);
   localparam int unsigned CNT_W = $clog2(MAXB + 1);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] AB_LAST   = CNT_W'(AB - 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB - 1);
   localparam logic [CNT_W-1:0] DB_CNT    = CNT_W'(DB);

   localparam logic [7:0] CH_WRITE = 8'h57;
   localparam logic [7:0] CH_READ  = 8'h52;
   localparam logic [7:0] CH_OK    = 8'h4B;
   localparam logic [7:0] CH_UNK   = 8'h3F;
   localparam logic [7:0] CH_FERR  = 8'h21;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_RESP, S_RESP_WAIT
   } state_t;

   // ---------------- receiver ----------------
   rx_state_t        rx_state_q, rx_state_d;
   logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic             rx_prev_q, rx_prev_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_ferr_q, rx_ferr_d;

   // Receiver: falling-edge start, mid-start recheck, mid-bit sampling
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_prev_d  = rx;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx) begin
               rx_state_d = RX_START;
               rx_cnt_d   = HALF_LAST;
            end
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               if (rx) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = DIV_LAST;
                  rx_bit_d   = 3'd0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - DIV_W'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_sh_d  = {rx, rx_sh_q[7:1]};
               rx_cnt_d = DIV_LAST;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - DIV_W'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_valid_d = rx;
               rx_ferr_d  = !rx;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q - DIV_W'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Receiver registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_prev_q  <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_prev_q  <= rx_prev_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   // ---------------- transmitter ----------------
   logic             tx_act_q, tx_act_d;
   logic [9:0]       tx_sh_q, tx_sh_d;
   logic [3:0]       tx_bit_q, tx_bit_d;
   logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
   logic             tx_q, tx_d;
   logic             tx_start_c;
   logic [7:0]       tx_byte_c;
   logic             tx_done_c;

   assign tx_done_c = tx_act_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);

   // Transmitter: start + 8 data + stop, each bit DIV clocks
   always_comb begin
      tx_act_d = tx_act_q;
      tx_sh_d  = tx_sh_q;
      tx_bit_d = tx_bit_q;
      tx_cnt_d = tx_cnt_q;
      tx_d     = tx_q;
      if (!tx_act_q) begin
         if (tx_start_c) begin
            tx_act_d = 1'b1;
            tx_sh_d  = {1'b1, tx_byte_c, 1'b0};
            tx_d     = 1'b0;
            tx_bit_d = 4'd0;
            tx_cnt_d = DIV_LAST;
         end
      end else if (tx_cnt_q == '0) begin
         if (tx_bit_q == 4'd9) begin
            tx_act_d = 1'b0;
            tx_d     = 1'b1;
         end else begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
            tx_bit_d = tx_bit_q + 4'd1;
            tx_cnt_d = DIV_LAST;
         end
      end else begin
         tx_cnt_d = tx_cnt_q - DIV_W'(1);
      end
   end

   // Transmitter registers; line returns high immediately on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_act_q <= 1'b0;
         tx_sh_q  <= '1;
         tx_bit_q <= '0;
         tx_cnt_q <= '0;
         tx_q     <= 1'b1;
      end else begin
         tx_act_q <= tx_act_d;
         tx_sh_q  <= tx_sh_d;
         tx_bit_q <= tx_bit_d;
         tx_cnt_q <= tx_cnt_d;
         tx_q     <= tx_d;
      end
   end

   // ---------------- command FSM ----------------
   state_t               state_q, state_d;
   logic                 write_q, write_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [addr_size-1:0] addr_q, addr_d;
   logic [wordsize-1:0]  wdata_q, wdata_d;
   logic [wordsize-1:0]  resp_q, resp_d;
   logic                 bus_enable_q, bus_enable_d;
   logic                 bus_write_en_q, bus_write_en_d;
   logic [addr_size-1:0] bus_addr_q, bus_addr_d;
   logic [wordsize-1:0]  bus_wdata_q, bus_wdata_d;
   logic                 busy_q, busy_d;

   // Command decode, bus access sequencing and response queueing
   always_comb begin
      state_d        = state_q;
      write_d        = write_q;
      cnt_d          = cnt_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      resp_d         = resp_q;
      bus_enable_d   = 1'b0;
      bus_write_en_d = 1'b0;
      bus_addr_d     = bus_addr_q;
      bus_wdata_d    = bus_wdata_q;
      tx_start_c     = 1'b0;
      tx_byte_c      = resp_q[wordsize-1 -: 8];
      case (state_q)
         S_IDLE: begin
            if (rx_valid_q) begin
               cnt_d = '0;
               if (rx_sh_q == CH_WRITE) begin
                  write_d = 1'b1;
                  state_d = S_ADDR;
               end else if (rx_sh_q == CH_READ) begin
                  write_d = 1'b0;
                  state_d = S_ADDR;
               end else begin
                  resp_d  = wordsize'(CH_UNK) << (wordsize - 8);
                  cnt_d   = CNT_W'(1);
                  state_d = S_RESP;
               end
            end
         end
         S_ADDR: begin
            if (rx_ferr_q) begin
               resp_d  = wordsize'(CH_FERR) << (wordsize - 8);
               cnt_d   = CNT_W'(1);
               state_d = S_RESP;
            end else if (rx_valid_q) begin
               addr_d = (addr_q << 8) | addr_size'(rx_sh_q);
               if (cnt_q == AB_LAST) begin
                  cnt_d   = '0;
                  state_d = write_q ? S_DATA : S_BUS_RD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DATA: begin
            if (rx_ferr_q) begin
               resp_d  = wordsize'(CH_FERR) << (wordsize - 8);
               cnt_d   = CNT_W'(1);
               state_d = S_RESP;
            end else if (rx_valid_q) begin
               wdata_d = (wdata_q << 8) | wordsize'(rx_sh_q);
               if (cnt_q == DB_LAST) begin
                  cnt_d   = '0;
                  state_d = S_BUS_WR;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_BUS_WR: begin
            resp_d  = wordsize'(CH_OK) << (wordsize - 8);
            cnt_d   = CNT_W'(1);
            state_d = S_RESP;
         end
         S_BUS_RD: begin
            resp_d  = bus_rdata;
            cnt_d   = DB_CNT;
            state_d = S_RESP;
         end
         S_RESP: begin
            tx_start_c = 1'b1;
            resp_d     = resp_q << 8;
            cnt_d      = cnt_q - CNT_W'(1);
            state_d    = S_RESP_WAIT;
         end
         S_RESP_WAIT: begin
            if (tx_done_c) state_d = (cnt_q == '0) ? S_IDLE : S_RESP;
         end
         default: state_d = S_IDLE;
      endcase

      // Bus strobe is registered so it coincides with the BUS_* state
      if (state_d == S_BUS_WR) begin
         bus_enable_d   = 1'b1;
         bus_write_en_d = 1'b1;
         bus_addr_d     = addr_d;
         bus_wdata_d    = wdata_d;
      end else if (state_d == S_BUS_RD) begin
         bus_enable_d   = 1'b1;
         bus_addr_d     = addr_d;
      end
      busy_d = (state_d != S_IDLE);
   end

   // FSM and bus output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         write_q        <= 1'b0;
         cnt_q          <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         resp_q         <= '0;
         bus_enable_q   <= 1'b0;
         bus_write_en_q <= 1'b0;
         bus_addr_q     <= '0;
         bus_wdata_q    <= '0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         write_q        <= write_d;
         cnt_q          <= cnt_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         resp_q         <= resp_d;
         bus_enable_q   <= bus_enable_d;
         bus_write_en_q <= bus_write_en_d;
         bus_addr_q     <= bus_addr_d;
         bus_wdata_q    <= bus_wdata_d;
         busy_q         <= busy_d;
      end
   end

   assign tx           = tx_q;
   assign bus_enable   = bus_enable_q;
   assign bus_write_en = bus_write_en_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_reflet_uart_bus_bridge.sv
// Directed bench for reflet_uart_bus_bridge at DIV = 10 clocks per bit.
module tb_reflet_uart_bus_bridge;

   logic        clk;
   logic        reset;
   logic        rx;
   logic        tx;
   logic        bus_enable;
   logic [15:0] bus_addr;
   logic        bus_write_en;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;
   logic        busy;

   int errors = 0;
   int checks = 0;

   reflet_uart_bus_bridge #(
      .wordsize (16),
      .addr_size(16),
      .clk_frec (96000),
      .baud     (9600)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .tx          (tx),
      .bus_enable  (bus_enable),
      .bus_addr    (bus_addr),
      .bus_write_en(bus_write_en),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational read responder
   assign bus_rdata = (bus_addr == 16'h0010) ? 16'hBEEF : 16'h0000;

   // Bus access recorder and strobe-rule watcher
   int          en_count = 0;
   int          bus_viol = 0;
   logic        prev_en  = 1'b0;
   logic [15:0] last_addr  = '0;
   logic [15:0] last_wdata = '0;
   logic        last_we    = 1'b0;

   always @(negedge clk) begin
      if (bus_enable === 1'b1) begin
         en_count   = en_count + 1;
         last_addr  = bus_addr;
         last_wdata = bus_wdata;
         last_we    = bus_write_en;
      end
      if (bus_enable === 1'b1 && prev_en === 1'b1) bus_viol = bus_viol + 1;
      if (bus_enable !== 1'b1 && bus_write_en !== 1'b0) bus_viol = bus_viol + 1;
      prev_en = bus_enable;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one 8N1 byte, LSB first, each bit 10 clocks
   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (10) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic wait_tx_low(input string tag);
      for (int i = 0; i < 2000 && tx !== 1'b0; i++) @(negedge clk);
      check_eq(tag, 32'(tx), 32'h0);
   endtask

   // Capture one tx byte, checking every bit holds for all 10 clocks
   task automatic recv_expect(input string tag, input logic [7:0] exp);
      logic [9:0] bits;
      int         width_err;
      logic       s;
      bits      = '0;
      width_err = 0;
      wait_tx_low({tag, "_start"});
      for (int i = 0; i < 100; i++) begin
         if (i > 0) @(negedge clk);
         s = tx;
         if (i % 10 == 0) bits[i / 10] = s;
         else if (s !== bits[i / 10]) width_err++;
      end
      check_eq(tag, 32'(bits[8:1]), 32'(exp));
      check_eq({tag, "_stop"}, 32'(bits[9]), 32'h1);
      check_eq({tag, "_width"}, 32'(width_err), 32'h0);
   endtask

   int base;
   int tx_low;
   int busy_hi;

   initial begin
      rx    = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_tx", 32'(tx), 32'h1);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_en", 32'(bus_enable), 32'h0);
      check_eq("rst_we", 32'(bus_write_en), 32'h0);
      check_eq("rst_addr", 32'(bus_addr), 32'h0);
      check_eq("rst_wdata", 32'(bus_wdata), 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Write 0x1234 to 0xFF0A
      base = en_count;
      fork
         begin
            send_byte(8'h57, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h0A, 1'b1);
            send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
         end
         recv_expect("wr_resp", 8'h4B);
      join
      check_eq("wr_busy_stop", 32'(busy), 32'h1);
      @(negedge clk);
      check_eq("wr_busy_after", 32'(busy), 32'h0);
      check_eq("wr_en_count", 32'(en_count - base), 32'h1);
      check_eq("wr_we", 32'(last_we), 32'h1);
      check_eq("wr_addr", 32'(last_addr), 32'hFF0A);
      check_eq("wr_wdata", 32'(last_wdata), 32'h1234);
      check_eq("wr_addr_hold", 32'(bus_addr), 32'hFF0A);
      check_eq("wr_we_idle", 32'(bus_write_en), 32'h0);

      // Read from 0x0010
      repeat (5) @(negedge clk);
      base = en_count;
      fork
         begin send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); end
         begin recv_expect("rd_b0", 8'hBE); recv_expect("rd_b1", 8'hEF); end
      join
      repeat (3) @(negedge clk);
      check_eq("rd_en_count", 32'(en_count - base), 32'h1);
      check_eq("rd_we", 32'(last_we), 32'h0);
      check_eq("rd_addr", 32'(last_addr), 32'h0010);
      check_eq("rd_wdata_hold", 32'(bus_wdata), 32'h1234);
      check_eq("rd_busy_after", 32'(busy), 32'h0);

      // Unknown command
      base = en_count;
      fork
         send_byte(8'h41, 1'b1);
         recv_expect("unk_resp", 8'h3F);
      join
      repeat (3) @(negedge clk);
      check_eq("unk_no_bus", 32'(en_count - base), 32'h0);
      check_eq("unk_idle", 32'(busy), 32'h0);

      // Framing error on first address byte, then a clean write
      base = en_count;
      fork
         begin send_byte(8'h57, 1'b1); send_byte(8'hFF, 1'b0); end
         recv_expect("ferr_resp", 8'h21);
      join
      repeat (20) @(negedge clk);
      check_eq("ferr_no_bus", 32'(en_count - base), 32'h0);
      check_eq("ferr_idle", 32'(busy), 32'h0);
      base = en_count;
      fork
         begin
            send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
            send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
         end
         recv_expect("wr2_resp", 8'h4B);
      join
      repeat (3) @(negedge clk);
      check_eq("wr2_en_count", 32'(en_count - base), 32'h1);
      check_eq("wr2_addr", 32'(last_addr), 32'h0020);
      check_eq("wr2_wdata", 32'(last_wdata), 32'hABCD);
      check_eq("wr2_we", 32'(last_we), 32'h1);

      // Start-bit glitch of 3 clocks
      base    = en_count;
      tx_low  = 0;
      busy_hi = 0;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_low++;
         if (busy !== 1'b0) busy_hi++;
      end
      check_eq("glitch_tx", 32'(tx_low), 32'h0);
      check_eq("glitch_busy", 32'(busy_hi), 32'h0);
      check_eq("glitch_no_bus", 32'(en_count - base), 32'h0);

      // Reset in the middle of a read response (data bit 6 of 0xBE is 0)
      fork
         begin send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); end
         begin wait_tx_low("rst_mid_start"); repeat (74) @(negedge clk); end
      join
      check_eq("rst_mid_tx_low", 32'(tx), 32'h0);
      check_eq("rst_mid_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("rst_mid_tx", 32'(tx), 32'h1);
      check_eq("rst_mid_busy0", 32'(busy), 32'h0);
      check_eq("rst_mid_en", 32'(bus_enable), 32'h0);
      repeat (20) @(negedge clk);
      base = en_count;
      fork
         begin send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); end
         begin recv_expect("rd2_b0", 8'hBE); recv_expect("rd2_b1", 8'hEF); end
      join
      repeat (3) @(negedge clk);
      check_eq("rd2_en_count", 32'(en_count - base), 32'h1);
      check_eq("rd2_addr", 32'(last_addr), 32'h0010);

      check_eq("bus_strobe_rules", 32'(bus_viol), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
